// File: rtl/axi4_wide_memory.sv
// AXI4-Lite memory slave with DATA_W-wide array, in-order read queue, MMIO console/pass outputs and SLVERR decode.
// Optional random back-pressure: define AXI_MEM_STALL_EN.
module axi4_wide_memory #(
    parameter int          DATA_W       = 32,
    parameter int          MEM_BYTES    = 131072,
    parameter int          RD_DEPTH     = 4,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter logic [31:0] PASS_ADDR    = 32'h2000_0000,
    parameter logic [31:0] PASS_VALUE   = 32'd123456789
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  mem_axi_awvalid,
    output logic                  mem_axi_awready,
    input  logic [31:0]           mem_axi_awaddr,
    input  logic [2:0]            mem_axi_awprot,
    input  logic                  mem_axi_wvalid,
    output logic                  mem_axi_wready,
    input  logic [DATA_W-1:0]     mem_axi_wdata,
    input  logic [DATA_W/8-1:0]   mem_axi_wstrb,
    output logic                  mem_axi_bvalid,
    input  logic                  mem_axi_bready,
    output logic [1:0]            mem_axi_bresp,
    input  logic                  mem_axi_arvalid,
    output logic                  mem_axi_arready,
    input  logic [31:0]           mem_axi_araddr,
    input  logic [2:0]            mem_axi_arprot,
    output logic                  mem_axi_rvalid,
    input  logic                  mem_axi_rready,
    output logic [DATA_W-1:0]     mem_axi_rdata,
    output logic [1:0]            mem_axi_rresp,
    output logic                  console_valid,
    output logic [7:0]            console_data,
    output logic                  tests_passed,
    output logic                  err_oob
);

    localparam int STRB_W = DATA_W / 8;
    localparam int WORDS  = MEM_BYTES / STRB_W;
    localparam int IDX_W  = $clog2(WORDS);
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int PTR_W  = $clog2(RD_DEPTH);
    localparam logic [32:0]    MEM_LIMIT = 33'(MEM_BYTES);
    localparam logic [PTR_W:0] OCC_MAX   = (PTR_W + 1)'(RD_DEPTH);
    localparam logic [1:0]     RESP_OKAY   = 2'b00;
    localparam logic [1:0]     RESP_SLVERR = 2'b10;

    // Handshake rule on every channel: a transfer happens on the rising edge
    // where valid && ready; valid and its payload hold until that edge.

    logic [DATA_W-1:0] memory [WORDS];

    logic unused_prot;
    assign unused_prot = ^{mem_axi_awprot, mem_axi_arprot};

    logic gate_ar, gate_aw, gate_w, gate_r, gate_b;

`ifdef AXI_MEM_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr <= 16'hACE1;
        else         lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign gate_ar = lfsr[0];
    assign gate_aw = lfsr[1];
    assign gate_w  = lfsr[2];
    assign gate_r  = lfsr[3];
    assign gate_b  = lfsr[4];
`else
    assign gate_ar = 1'b1;
    assign gate_aw = 1'b1;
    assign gate_w  = 1'b1;
    assign gate_r  = 1'b1;
    assign gate_b  = 1'b1;
`endif

    // Keeps every ready low while in reset and for the release edge itself.
    logic ready_en;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) ready_en <= 1'b0;
        else         ready_en <= 1'b1;
    end

    function automatic logic in_mem(input logic [31:0] a);
        return {1'b0, a} < MEM_LIMIT;
    endfunction

    function automatic logic [1:0] decode_resp(input logic [31:0] a);
        if (in_mem(a) || a == CONSOLE_ADDR || a == PASS_ADDR) return RESP_OKAY;
        return RESP_SLVERR;
    endfunction

    // ---------------- read path ----------------
    logic [31:0]      fifo_addr [RD_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   fifo_count;
    logic             fifo_empty, occ_full, ar_push, r_load;
    logic [31:0]      head_addr;
    logic [1:0]       head_resp;

    assign fifo_empty = (fifo_count == '0);
    // The loaded R register is one of the RD_DEPTH outstanding read slots.
    assign occ_full   = (fifo_count + {{PTR_W{1'b0}}, mem_axi_rvalid}) >= OCC_MAX;
    assign mem_axi_arready = ready_en && !occ_full && gate_ar;
    assign ar_push    = mem_axi_arvalid && mem_axi_arready;
    assign r_load     = (!mem_axi_rvalid || mem_axi_rready) && !fifo_empty && gate_r;
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_resp  = decode_resp(head_addr);

    always_ff @(posedge clk) begin
        if (ar_push) fifo_addr[wr_ptr] <= mem_axi_araddr;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (ar_push) wr_ptr <= wr_ptr + 1'b1;
            if (r_load)  rd_ptr <= rd_ptr + 1'b1;
            case ({ar_push, r_load})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Memory is sampled before this edge's commit lands, so a same-edge read sees old data.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_axi_rvalid <= 1'b0;
            mem_axi_rdata  <= '0;
            mem_axi_rresp  <= RESP_OKAY;
        end else if (r_load) begin
            mem_axi_rvalid <= 1'b1;
            mem_axi_rdata  <= in_mem(head_addr) ? memory[head_addr[OFF_W +: IDX_W]] : '0;
            mem_axi_rresp  <= head_resp;
        end else if (mem_axi_rready) begin
            mem_axi_rvalid <= 1'b0;
        end
    end

    // ---------------- write path ----------------
    logic              aw_full, w_full, commit;
    logic [31:0]       aw_addr;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;
    logic [1:0]        wr_resp;
    logic              wr_console, wr_pass;

    assign mem_axi_awready = ready_en && !aw_full && gate_aw;
    assign mem_axi_wready  = ready_en && !w_full && gate_w;
    assign commit     = aw_full && w_full && (!mem_axi_bvalid || mem_axi_bready) && gate_b;
    assign wr_resp    = decode_resp(aw_addr);
    assign wr_console = !in_mem(aw_addr) && aw_addr == CONSOLE_ADDR;
    assign wr_pass    = !in_mem(aw_addr) && aw_addr == PASS_ADDR;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            w_strb  <= '0;
        end else begin
            if (commit) begin
                aw_full <= 1'b0;
            end else if (mem_axi_awvalid && mem_axi_awready) begin
                aw_full <= 1'b1;
                aw_addr <= mem_axi_awaddr;
            end
            if (commit) begin
                w_full <= 1'b0;
            end else if (mem_axi_wvalid && mem_axi_wready) begin
                w_full <= 1'b1;
                w_data <= mem_axi_wdata;
                w_strb <= mem_axi_wstrb;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && in_mem(aw_addr)) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (w_strb[b]) memory[aw_addr[OFF_W +: IDX_W]][b*8 +: 8] <= w_data[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_axi_bvalid <= 1'b0;
            mem_axi_bresp  <= RESP_OKAY;
            console_valid  <= 1'b0;
            console_data   <= '0;
            tests_passed   <= 1'b0;
            err_oob        <= 1'b0;
        end else begin
            console_valid <= commit && wr_console;
            if (commit) begin
                mem_axi_bvalid <= 1'b1;
                mem_axi_bresp  <= wr_resp;
            end else if (mem_axi_bready) begin
                mem_axi_bvalid <= 1'b0;
            end
            if (commit && wr_console)                        console_data <= w_data[7:0];
            if (commit && wr_pass && w_data[31:0] == PASS_VALUE) tests_passed <= 1'b1;
            if ((commit && wr_resp == RESP_SLVERR) || (r_load && head_resp == RESP_SLVERR))
                err_oob <= 1'b1;
        end
    end

endmodule

// File: doc/axi4_wide_memory.md
# axi4_wide_memory

Parametrised AXI4-Lite memory slave for the RVV simulation and FPGA bring-up environment, replacing the fixed 32-bit, single-outstanding memory model. It supports data widths up to 128 bits for vector load/store traffic, a queue of outstanding reads, SLVERR responses instead of simulation aborts, and the console and test-pass MMIO addresses as synthesizable outputs. It sits between the core's AXI master port and the bench or board top.

## Interface
- DATA_W, 32: AXI data width; one of 32, 64, 128.
- MEM_BYTES, 131072: array size in bytes; power of two, multiple of DATA_W/8.
- RD_DEPTH, 4: outstanding read-address FIFO depth; power of two, at least 2.
- CONSOLE_ADDR, 32'h1000_0000: byte-write console address.
- PASS_ADDR, 32'h2000_0000: test-pass register address.
- PASS_VALUE, 32'd123456789: magic value that sets tests_passed.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- mem_axi_awvalid / awready  in / out  1 / 1  write-address handshake.
- mem_axi_awaddr  in  32  write byte address.
- mem_axi_awprot  in  3  ignored.
- mem_axi_wvalid / wready  in / out  1 / 1  write-data handshake.
- mem_axi_wdata  in  DATA_W  write data.
- mem_axi_wstrb  in  DATA_W/8  byte enables.
- mem_axi_bvalid / bready  out / in  1 / 1  write response.
- mem_axi_bresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
- mem_axi_arvalid / arready  in / out  1 / 1  read-address handshake.
- mem_axi_araddr  in  32  read byte address.
- mem_axi_arprot  in  3  ignored.
- mem_axi_rvalid / rready  out / in  1 / 1  read data handshake.
- mem_axi_rdata  out  DATA_W  read data.
- mem_axi_rresp  out  2  read response.
- console_valid  out  1  one-cycle pulse on a console write.
- console_data  out  8  wdata[7:0] of that write.
- tests_passed  out  1  sticky pass flag.
- err_oob  out  1  sticky out-of-bounds flag.

## Operation
- Array is `memory`, DATA_W-wide words, MEM_BYTES*8/DATA_W entries. It is not reset; the bench preloads it hierarchically. Word index is addr / (DATA_W/8); low address bits are ignored.
- Read path:
  - arready = !fifo_full (gated by the stall term). A handshake pushes {addr} into the RD_DEPTH FIFO.
  - The R output register loads from the FIFO head when it is empty, or being drained by rvalid && rready, and the FIFO is non-empty (gated).
  - Responses are strictly in order.
- Write path:
  - AW and W each have a one-entry latch; awready = !aw_full and wready = !w_full (gated).
  - Commit happens when both latches are full and B is free (bvalid low, or bvalid && bready this cycle). Commit writes the strobed bytes, clears both latches, and sets bvalid.
- Address decode (reads and writes):
  - addr < MEM_BYTES: array access, OKAY.
  - addr == CONSOLE_ADDR: write pulses console_valid with console_data = wdata[7:0]; read returns 0 with OKAY.
  - addr == PASS_ADDR: write with wdata[31:0] == PASS_VALUE sets tests_passed; any other value has no effect; read returns 0 with OKAY.
  - Otherwise: write discarded, read returns 0; resp SLVERR; err_oob set.
- Same-edge read pop and write commit to the same word: the read returns pre-write data.
- Reset (including mid-transaction): FIFO, latches and all flags clear; any in-flight transaction is dropped; memory contents are kept.

## Timing
- Reset values: awready, wready, arready, rvalid, bvalid, console_valid, tests_passed and err_oob are 0; rdata is 0; rresp and bresp are 2'b00. Ready signals rise in the first cycle after resetn deasserts.
- Read latency with stall off: AR handshake at edge N gives rvalid high after edge N+1. Back-to-back ARs give one beat per cycle when rready is held high.
- Write latency with stall off: AW and W handshakes at edge N (same or different cycles, the later one counts) give commit and bvalid high after edge N+1.
- rvalid/rdata/rresp and bvalid/bresp hold stable until their handshake completes.
- FIFO full: arready stays low until a pop occurs. Pop and push on the same edge are legal at full and at empty.
- console_valid is high for exactly one cycle per commit.

## Configuration
- AXI_MEM_STALL_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1, reloaded on reset) advances every cycle.
  - A low value of bit0/1/2 masks arready/awready/wready. A low bit3 blocks the R register load. A low bit4 blocks write commit.
  - Handshake rules above still hold; latency becomes variable.
- Not defined: no LFSR; all gates are permanently open; the minimum latencies above apply exactly.

## Test plan
- Preload word 0x40 = 0xDEADBEEF (DATA_W=32); AR 0x100 at cycle 5 with rready=1 -> rvalid at cycle 6, rdata 0xDEADBEEF, rresp 00.
- DATA_W=128: write 0x20 with wstrb 16'h000F and data all-ones over a zeroed array -> bvalid one cycle after the later of AW/W; read back 0x...0000_FFFFFFFF.
- RD_DEPTH=4, rready=0, five ARs -> four accepted, arready low; raise rready -> four in-order beats on consecutive cycles, then the fifth AR is accepted.
- Write 123456789 to 0x2000_0000 -> tests_passed=1 and stays 1; write 0x41 to 0x1000_0000 -> one-cycle console_valid with data 0x41.
- AR 0x3000_0000 and write 0x0004_0000 -> rresp and bresp 2'b10, rdata 0, memory unchanged, err_oob=1.
- Assert resetn=0 with 2 reads queued and bvalid pending -> rvalid, bvalid and flags go 0 immediately; after release, previously written data still reads back.
